// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: segment bit order,
// glyph codes and a small width helper.
package seg7_pkg;

  // Segment order on the bus is {g,f,e,d,c,b,a}; bit 0 is segment a.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_bits_t;

  typedef logic [6:0] seg_code_t;

  localparam seg_code_t SEG_0   = 7'b0111111;
  localparam seg_code_t SEG_1   = 7'b0000110;
  localparam seg_code_t SEG_2   = 7'b1011011;
  localparam seg_code_t SEG_3   = 7'b1001111;
  localparam seg_code_t SEG_4   = 7'b1100110;
  localparam seg_code_t SEG_5   = 7'b1101101;
  localparam seg_code_t SEG_6   = 7'b1111101;
  localparam seg_code_t SEG_7   = 7'b0000111;
  localparam seg_code_t SEG_8   = 7'b1111111;
  localparam seg_code_t SEG_9   = 7'b1100111;
  localparam seg_code_t SEG_ERR = 7'b1111001;
  localparam seg_code_t SEG_OFF = 7'b0000000;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_if.sv
// Bundle between the clock/alarm datapath (master) and the scan driver (slave),
// including the display pins the driver produces.
interface seg7_if
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4
);

  logic [4*N_DIGITS-1:0] digits_in;
  logic                  load;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blink_mask;
  logic                  lz_suppress;
  seg_code_t             seg_out;
  logic                  dp_out;
  logic [N_DIGITS-1:0]   an_out;
  logic                  frame_tick;

  modport master (
    output digits_in, load, dp_in, blink_mask, lz_suppress,
    input  seg_out, dp_out, an_out, frame_tick
  );

  modport slave (
    input  digits_in, load, dp_in, blink_mask, lz_suppress,
    output seg_out, dp_out, an_out, frame_tick
  );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD to 7-segment decoder; values 10-15 render as 'E'.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output seg_code_t  seg
);

  always_comb begin
    seg = SEG_ERR;
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: shadow digit registers, scan/frame/blink
// counters, leading-zero and blink blanking, and registered pin outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input logic   clk,
  input logic   rst,
  seg7_if.slave bus
);

  localparam int CNT_W = width_for(SCAN_DIV);
  localparam int IDX_W = width_for(N_DIGITS);
  localparam int FRM_W = width_for(BLINK_FRAMES);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  // Idle pin levels; XOR-ing with these applies the board polarity.
  localparam seg_code_t           SEG_IDLE = {7{SEG_ACTIVE_LOW}};
  localparam logic                DP_IDLE  = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] AN_IDLE  = {N_DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRM_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                  blink_ph_q, blink_ph_d;
  logic [4*N_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
  logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  seg_code_t             seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  frame_tick_q, frame_tick_d;

  logic [N_DIGITS-1:0]   lz_blank;
  logic                  zero_run;
  logic [3:0]            cur_value;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  cur_lz;
  logic [N_DIGITS-1:0]   an_sel;
  logic                  blank;
  seg_code_t             dec_seg;

  // Dwell counter drives the digit index, which drives the frame and blink counters.
  always_comb begin
    scan_cnt_d   = scan_cnt_q + 1'b1;
    idx_d        = idx_q;
    frame_cnt_d  = frame_cnt_q;
    blink_ph_d   = blink_ph_q;
    frame_tick_d = 1'b0;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d        = '0;
        frame_tick_d = 1'b1;
        if (frame_cnt_q == FRM_LAST) begin
          frame_cnt_d = '0;
          blink_ph_d  = ~blink_ph_q;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    shadow_digits_d = bus.load ? bus.digits_in : shadow_digits_q;
    shadow_dp_d     = bus.load ? bus.dp_in     : shadow_dp_q;
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run & (shadow_digits_q[4*i +: 4] == 4'd0);
      lz_blank[i] = zero_run && (i != 0);
    end
  end

  always_comb begin
    cur_value = '0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    an_sel    = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_value = shadow_digits_q[4*i +: 4];
        cur_dp    = shadow_dp_q[i];
        cur_blink = bus.blink_mask[i];
        cur_lz    = lz_blank[i];
        an_sel[i] = 1'b1;
      end
    end
  end

  seg7_decoder u_decoder (
    .value (cur_value),
    .seg   (dec_seg)
  );

  // Blanking forces everything inactive first; polarity is applied last.
  always_comb begin
    blank = (bus.lz_suppress && cur_lz) || (blink_ph_q && cur_blink);
    seg_d = (blank ? SEG_OFF : dec_seg) ^ SEG_IDLE;
    dp_d  = (~blank & cur_dp) ^ DP_IDLE;
    an_d  = (blank ? '0 : an_sel) ^ AN_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q      <= '0;
      idx_q           <= '0;
      frame_cnt_q     <= '0;
      blink_ph_q      <= 1'b0;
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
      seg_q           <= SEG_IDLE;
      dp_q            <= DP_IDLE;
      an_q            <= AN_IDLE;
      frame_tick_q    <= 1'b0;
    end else begin
      scan_cnt_q      <= scan_cnt_d;
      idx_q           <= idx_d;
      frame_cnt_q     <= frame_cnt_d;
      blink_ph_q      <= blink_ph_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
      an_q            <= an_d;
      frame_tick_q    <= frame_tick_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.an_out     = an_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with N_DIGITS=4,
// SCAN_DIV=4, BLINK_FRAMES=2 and active-high pins.
module tb_seg7_scan_driver;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S9 = 7'b1100111;
  localparam logic [6:0] SE = 7'b1111001;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  seg7_if #(.N_DIGITS(4)) bus ();

  seg7_scan_driver #(
    .N_DIGITS       (4),
    .SCAN_DIV       (4),
    .BLINK_FRAMES   (2),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] digits, input logic [3:0] dp);
    bus.digits_in = digits;
    bus.dp_in     = dp;
    bus.load      = 1'b1;
    tick();
    bus.load      = 1'b0;
  endtask

  // Returns just after the edge that raised frame_tick; next cycle shows digit 0.
  task automatic syncFrame(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.frame_tick) found = 1'b1;
    end
    checkOutput({tag, "_sync"}, 32'(found), 32'd1);
  endtask

  task automatic checkFrame(input string tag, input logic [15:0] exp_an,
                            input logic [27:0] exp_seg, input logic [3:0] exp_dp);
    syncFrame(tag);
    for (int k = 0; k < 16; k++) begin
      int d;
      d = k / 4;
      tick();
      checkOutput($sformatf("%s_an_c%0d", tag, k), 32'(bus.an_out), 32'(exp_an[4*d +: 4]));
      checkOutput($sformatf("%s_seg_c%0d", tag, k), 32'(bus.seg_out), 32'(exp_seg[7*d +: 7]));
      checkOutput($sformatf("%s_dp_c%0d", tag, k), 32'(bus.dp_out), 32'(exp_dp[d]));
      checkOutput($sformatf("%s_tick_c%0d", tag, k), 32'(bus.frame_tick), 32'(k == 15));
    end
  endtask

  initial begin
    logic [27:0] seg1234;
    int          tick_count;
    int          idx;
    int          frame;
    bit          dark;

    seg1234         = {S1, S2, S3, S4};
    bus.digits_in   = '0;
    bus.dp_in       = '0;
    bus.load        = 1'b0;
    bus.blink_mask  = '0;
    bus.lz_suppress = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    checkOutput("reset_an", 32'(bus.an_out), 32'd0);
    checkOutput("reset_seg", 32'(bus.seg_out), 32'd0);
    checkOutput("reset_dp", 32'(bus.dp_out), 32'd0);
    checkOutput("reset_tick", 32'(bus.frame_tick), 32'd0);
    rst = 1'b0;

    applyStimulus(16'h1234, 4'b0010);
    checkFrame("scan1234", 16'h8421, seg1234, 4'b0010);
    tick_count = 0;
    repeat (32) begin
      tick();
      if (bus.frame_tick) tick_count++;
    end
    checkOutput("tick_count_32", 32'(tick_count), 32'd2);

    applyStimulus(16'h00A0, 4'b0000);
    checkFrame("err_glyph", 16'h8421, {S0, S0, SE, S0}, 4'b0000);

    bus.lz_suppress = 1'b1;
    applyStimulus(16'h0045, 4'b0000);
    checkFrame("lz_0045", 16'h0021, {7'd0, 7'd0, S4, S5}, 4'b0000);
    applyStimulus(16'h0000, 4'b0000);
    checkFrame("lz_0000", 16'h0001, {7'd0, 7'd0, 7'd0, S0}, 4'b0000);
    bus.lz_suppress = 1'b0;

    // Blink phases are counted from reset release; cycle c=1 is the first released edge.
    bus.blink_mask = 4'b0001;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    applyStimulus(16'h1234, 4'b0000);
    for (int c = 2; c <= 96; c++) begin
      tick();
      if ((c - 1) % 4 == 2) begin
        idx   = ((c - 1) / 4) % 4;
        frame = (c - 1) / 16;
        dark  = (idx == 0) && (frame == 2 || frame == 3);
        checkOutput($sformatf("blink_an_f%0d_d%0d", frame, idx), 32'(bus.an_out),
                    dark ? 32'd0 : (32'd1 << idx));
        checkOutput($sformatf("blink_seg_f%0d_d%0d", frame, idx), 32'(bus.seg_out),
                    dark ? 32'd0 : 32'(seg1234[7*idx +: 7]));
      end
    end
    bus.blink_mask = 4'b0000;

    syncFrame("wrap_load");
    repeat (15) tick();
    bus.digits_in = 16'h0009;
    bus.dp_in     = 4'b0001;
    bus.load      = 1'b1;
    tick();
    bus.load      = 1'b0;
    checkOutput("wrap_load_tick", 32'(bus.frame_tick), 32'd1);
    checkOutput("wrap_load_old_an", 32'(bus.an_out), 32'b1000);
    checkOutput("wrap_load_old_seg", 32'(bus.seg_out), 32'(S1));
    tick();
    checkOutput("wrap_load_new_an", 32'(bus.an_out), 32'b0001);
    checkOutput("wrap_load_new_seg", 32'(bus.seg_out), 32'(S9));
    checkOutput("wrap_load_new_dp", 32'(bus.dp_out), 32'd1);

    syncFrame("mid_rst");
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_an", 32'(bus.an_out), 32'd0);
    checkOutput("mid_rst_seg", 32'(bus.seg_out), 32'd0);
    checkOutput("mid_rst_dp", 32'(bus.dp_out), 32'd0);
    checkOutput("mid_rst_tick", 32'(bus.frame_tick), 32'd0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c <= 5) begin
        checkOutput($sformatf("post_rst_an_c%0d", c), 32'(bus.an_out), (c <= 4) ? 32'b0001 : 32'b0010);
        checkOutput($sformatf("post_rst_seg_c%0d", c), 32'(bus.seg_out), 32'(S0));
        checkOutput($sformatf("post_rst_dp_c%0d", c), 32'(bus.dp_out), 32'd0);
      end
      if (c >= 15) begin
        checkOutput($sformatf("post_rst_tick_c%0d", c), 32'(bus.frame_tick), 32'(c == 16));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
